// File: rtl/teller_dispatch_arbiter.sv
// ============================================================================
// Module  : teller_dispatch_arbiter
// Brief   : Round-robin dispatch of the head-of-queue customer to a free
//           teller. Confirms departure on the front photocell and issues dec.
//           Optional macro DISPATCH_STATS_EN enables saturating dispatch and
//           no-show counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module teller_dispatch_arbiter #(
    parameter int N       = 3,
    parameter int T       = 3,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     Tcount,
    input  logic [N-1:0]   Pcount,
    input  logic           front_pulse,
    input  logic [T-1:0]   t_done,
    output logic           call_valid,
    output logic [1:0]     call_id,
    output logic [T-1:0]   t_grant,
    output logic           dec,
    output logic [T-1:0]   busy,
    output logic           no_show,
    output logic [7:0]     served_cnt,
    output logic [7:0]     noshow_cnt
);

    localparam int         c_TW      = $clog2(TIMEOUT);
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_CALL = 1'b1;

    logic [0:0]     r_state;
    logic [c_TW-1:0] r_timer;
    logic [1:0]     r_rr;
    logic           r_call_valid;
    logic [1:0]     r_call_id;
    logic [T-1:0]   r_grant;
    logic           r_dec;
    logic [T-1:0]   r_busy;
    logic           r_no_show;

    logic [T-1:0]   w_elig;
    logic [T-1:0]   w_onehot;
    logic [1:0]     w_sel;
    logic [1:0]     w_idx;
    logic           w_any;
    logic           w_in_call;
    logic           w_abort;
    logic           w_confirm;
    logic           w_timeout;

    generate
        for (genvar g = 0; g < T; g++) begin : g_elig
            assign w_elig[g] = (Tcount > 2'(g)) && !r_busy[g];
        end
    endgenerate

    // Scan downward so the nearest eligible teller after the pointer wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = 2'd0;
        w_idx = 2'd0;
        for (int k = T; k >= 1; k--) begin
            w_idx = 2'((int'(r_rr) + k) % T);
            if (w_elig[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < T; i++) begin
            w_onehot[i] = (w_sel == 2'(i));
        end
    end

    assign w_in_call = (r_state == c_ST_CALL);
    assign w_abort   = w_in_call && (Pcount == '0);
    assign w_confirm = w_in_call && !w_abort && front_pulse;
    assign w_timeout = w_in_call && !w_abort && !front_pulse &&
                       (r_timer == c_TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_timer      <= '0;
            r_rr         <= 2'(T - 1);
            r_call_valid <= 1'b0;
            r_call_id    <= 2'd0;
            r_grant      <= '0;
            r_dec        <= 1'b0;
            r_busy       <= '0;
            r_no_show    <= 1'b0;
        end else begin
            r_dec     <= 1'b0;
            r_no_show <= 1'b0;
            // A confirm sets the called teller's bit after any same-cycle t_done.
            r_busy    <= (r_busy & ~t_done) | (w_confirm ? r_grant : '0);
            case (r_state)
                c_ST_IDLE: begin
                    if ((Pcount != '0) && w_any) begin
                        r_state      <= c_ST_CALL;
                        r_call_valid <= 1'b1;
                        r_call_id    <= w_sel;
                        r_grant      <= w_onehot;
                        r_rr         <= w_sel;
                        r_timer      <= '0;
                    end
                end
                c_ST_CALL: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_abort || w_confirm || w_timeout) begin
                        r_state      <= c_ST_IDLE;
                        r_call_valid <= 1'b0;
                        r_grant      <= '0;
                        r_timer      <= '0;
                        r_dec        <= w_confirm || w_timeout;
                        r_no_show    <= w_timeout;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign call_valid = r_call_valid;
    assign call_id    = r_call_id;
    assign t_grant    = r_grant;
    assign dec        = r_dec;
    assign busy       = r_busy;
    assign no_show    = r_no_show;

`ifdef DISPATCH_STATS_EN
    logic [7:0] r_served;
    logic [7:0] r_noshow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_served <= 8'd0;
            r_noshow <= 8'd0;
        end else begin
            if (w_confirm && (r_served != 8'hFF)) r_served <= r_served + 8'd1;
            if (w_timeout && (r_noshow != 8'hFF)) r_noshow <= r_noshow + 8'd1;
        end
    end

    assign served_cnt = r_served;
    assign noshow_cnt = r_noshow;
`else
    assign served_cnt = 8'd0;
    assign noshow_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_teller_dispatch_arbiter.sv
// ============================================================================
// Module  : tb_teller_dispatch_arbiter
// Brief   : Directed self-checking bench for teller_dispatch_arbiter with a
//           queue of expected grants. Honours DISPATCH_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_teller_dispatch_arbiter;

    localparam int c_N = 3;
    localparam int c_T = 3;

    logic           clk;
    logic           rst;
    logic [1:0]     Tcount;
    logic [c_N-1:0] Pcount;
    logic           front_pulse;
    logic [c_T-1:0] t_done;
    logic           call_valid;
    logic [1:0]     call_id;
    logic [c_T-1:0] t_grant;
    logic           dec;
    logic [c_T-1:0] busy;
    logic           no_show;
    logic [7:0]     served_cnt;
    logic [7:0]     noshow_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

`ifdef DISPATCH_STATS_EN
    localparam logic [7:0] c_EXP_SAT    = 8'd255;
    localparam logic [7:0] c_EXP_NOSHOW = 8'd1;
`else
    localparam logic [7:0] c_EXP_SAT    = 8'd0;
    localparam logic [7:0] c_EXP_NOSHOW = 8'd0;
`endif

    teller_dispatch_arbiter #(.N(c_N), .T(c_T), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .Tcount      (Tcount),
        .Pcount      (Pcount),
        .front_pulse (front_pulse),
        .t_done      (t_done),
        .call_valid  (call_valid),
        .call_id     (call_id),
        .t_grant     (t_grant),
        .dec         (dec),
        .busy        (busy),
        .no_show     (no_show),
        .served_cnt  (served_cnt),
        .noshow_cnt  (noshow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_call(input int id);
        exp_q.push_back(id);
    endtask

    // Waits (bounded) for a call, then checks it against the oldest expectation.
    task automatic wait_call(input string tag);
        int e;
        for (int i = 0; i < 40 && !call_valid; i++) step();
        chk({tag, "_valid"}, 32'(call_valid), 32'd1);
        e = exp_q.pop_front();
        chk({tag, "_id"}, 32'(call_id), 32'(e));
        chk({tag, "_grant"}, 32'(t_grant), 32'(1 << e));
    endtask

    task automatic confirm(input string tag);
        front_pulse = 1'b1;
        step();
        front_pulse = 1'b0;
        chk({tag, "_dec"}, 32'(dec), 32'd1);
        chk({tag, "_cv_drop"}, 32'(call_valid & (t_grant == '0 ? 1'b0 : 1'b1)), 32'd0);
        step();
        chk({tag, "_dec_once"}, 32'(dec), 32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        Tcount      = 2'd3;
        Pcount      = 3'd2;
        front_pulse = 1'b0;
        t_done      = '0;
        step();
        step();

        chk("rst_call_valid", 32'(call_valid), 32'd0);
        chk("rst_call_id",    32'(call_id),    32'd0);
        chk("rst_t_grant",    32'(t_grant),    32'd0);
        chk("rst_dec",        32'(dec),        32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_no_show",    32'(no_show),    32'd0);
        chk("rst_served",     32'(served_cnt), 32'd0);
        chk("rst_noshow_cnt", 32'(noshow_cnt), 32'd0);

        // First grant lands on teller 0 one cycle after release.
        expect_call(0);
        rst = 1'b1;
        step();
        chk("first_latency", 32'(call_valid), 32'd1);
        wait_call("first");
        confirm("first");
        chk("first_busy", 32'(busy), 32'b001);

        expect_call(1);
        wait_call("rr1");
        confirm("rr1");
        expect_call(2);
        wait_call("rr2");
        confirm("rr2");
        chk("rr_busy_all", 32'(busy), 32'b111);
        chk("rr_no_free", 32'(call_valid), 32'd0);

        t_done = 3'b010;
        step();
        t_done = '0;
        chk("tdone_busy", 32'(busy), 32'b101);
        expect_call(1);
        wait_call("rr_after_done");

        // No front pulse: no-show after 15 CALL cycles.
        for (int i = 0; i < 14; i++) begin
            step();
            chk("to_wait_dec", 32'({dec, no_show, call_valid}), 32'b001);
        end
        step();
        chk("to_no_show", 32'(no_show), 32'd1);
        chk("to_dec", 32'(dec), 32'd1);
        chk("to_busy", 32'(busy), 32'b101);
        chk("to_noshow_cnt", 32'(noshow_cnt), 32'(c_EXP_NOSHOW));
        step();
        chk("to_pulse_once", 32'({dec, no_show}), 32'd0);

        // Queue empties while calling: abort without dec.
        expect_call(1);
        wait_call("pre_abort");
        Pcount = 3'd0;
        step();
        chk("abort_cv", 32'(call_valid), 32'd0);
        chk("abort_grant", 32'(t_grant), 32'd0);
        chk("abort_dec", 32'(dec), 32'd0);
        step();
        chk("abort_dec2", 32'(dec), 32'd0);
        chk("abort_busy", 32'(busy), 32'b101);

        Tcount = 2'd1;
        Pcount = 3'd5;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tc1_blocked", 32'(call_valid), 32'd0);
        end
        t_done = 3'b001;
        step();
        t_done = '0;
        chk("tc1_busy", 32'(busy), 32'b100);
        expect_call(0);
        wait_call("tc1_grant");

        // Asynchronous reset in the middle of a call.
        rst = 1'b0;
        #1;
        chk("mid_rst_cv", 32'(call_valid), 32'd0);
        chk("mid_rst_grant", 32'(t_grant), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_dec", 32'(dec), 32'd0);
        chk("mid_rst_noshow_cnt", 32'(noshow_cnt), 32'd0);
        step();
        chk("mid_rst_hold_dec", 32'(dec), 32'd0);

        Tcount = 2'd3;
        t_done = 3'b111;
        rst    = 1'b1;
        for (int k = 0; k < 300; k++) begin
            expect_call(k % 3);
            wait_call("sat");
            confirm("sat");
        end
        t_done = '0;
        Pcount = 3'd0;
        step();
        step();
        chk("sat_served", 32'(served_cnt), 32'(c_EXP_SAT));
        chk("sat_noshow_cnt", 32'(noshow_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
